// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson / one-hot ring sequencer: mode and
// direction encodings plus the state-legality helper.
package johnson_pkg;

  typedef enum logic {
    MODE_JOHNSON = 1'b0,
    MODE_RING    = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest register the legality helper can inspect.
  localparam int MAX_N = 64;

  // Legality of the low n bits of v in the given mode.
  // Johnson: at most one 0/1 boundary between neighbouring bits. That covers
  // all-zeros, all-ones, 0..01..1 and 1..10..0, which are exactly the 2n states
  // reachable from zero.
  // Ring: exactly one bit set.
  function automatic logic johnson_legal(input logic [MAX_N-1:0] v,
                                         input int               n,
                                         input mode_e            m);
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && v[i]) ones++;
    end
    for (int i = 0; i < MAX_N - 1; i++) begin
      if (i + 1 < n && v[i] != v[i+1]) edges++;
    end
    if (m == MODE_RING) return (ones == 1);
    return (edges <= 1);
  endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational decode of the sequencer state into a phase index and a
// legality flag for the current mode. Illegal states decode to phase 0.
module johnson_phase_decode
  import johnson_pkg::*;
#(
  parameter int N  = 10,
  parameter int PW = $clog2(2*N)
) (
  input  logic [N-1:0]  count,
  input  logic          mode,
  output logic [PW-1:0] phase,
  output logic          legal
);

  logic [MAX_N-1:0] count_ext;
  int               pc;
  int               ring_idx;

  // Popcount, set-bit index and legality, then pick the phase for the mode.
  always_comb begin
    count_ext         = '0;
    count_ext[N-1:0]  = count;
    legal             = johnson_legal(count_ext, N, mode_e'(mode));
    pc                = 0;
    ring_idx          = 0;
    for (int i = 0; i < N; i++) begin
      if (count[i]) begin
        pc++;
        ring_idx = i;
      end
    end
    phase = '0;
    if (legal) begin
      if (mode_e'(mode) == MODE_RING) begin
        phase = PW'(ring_idx);
      end else if (!count[N-1]) begin
        phase = PW'(pc);
      end else begin
        phase = PW'(2*N - pc);
      end
    end
  end

endmodule

// File: rtl/johnson_ring_seq.sv
// Johnson / one-hot ring sequencer: up/down stepping, synchronous load,
// self-correction of illegal states on an enabled step, decoded phase,
// and registered one-cycle wrap / fault strobes.
module johnson_ring_seq
  import johnson_pkg::*;
#(
  parameter  int N  = 10,
  localparam int PW = $clog2(2*N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          dir,
  input  logic          mode,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  count,
  output logic [PW-1:0] phase,
  output logic          wrap,
  output logic          fault
);

  localparam logic [PW-1:0] LAST_J = PW'(2*N - 1);
  localparam logic [PW-1:0] LAST_R = PW'(N - 1);

  logic [N-1:0]  count_q, count_d;
  logic          wrap_q,  wrap_d;
  logic          fault_q, fault_d;
  logic          legal;
  logic [PW-1:0] last_phase;

  johnson_phase_decode #(.N(N), .PW(PW)) u_decode (
    .count (count_q),
    .mode  (mode),
    .phase (phase),
    .legal (legal)
  );

  assign last_phase = (mode_e'(mode) == MODE_RING) ? LAST_R : LAST_J;

  // Next state: load beats enable beats hold; illegal states are only
  // repaired when a step is requested, and that cycle takes no step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    fault_d = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (enable) begin
      if (!legal) begin
        count_d = (mode_e'(mode) == MODE_RING) ? N'(1) : '0;
        fault_d = 1'b1;
      end else begin
        unique case ({mode_e'(mode) == MODE_RING, dir == DIR_DOWN})
          2'b00: count_d = {count_q[N-2:0], ~count_q[N-1]};
          2'b01: count_d = {~count_q[0], count_q[N-1:1]};
          2'b10: count_d = {count_q[N-2:0], count_q[N-1]};
          default: count_d = {count_q[0], count_q[N-1:1]};
        endcase
        wrap_d = (dir == DIR_DOWN) ? (phase == '0) : (phase == last_phase);
      end
    end
  end

  // State and strobe registers; reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      fault_q <= fault_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_johnson_ring_seq.sv
// Bench for johnson_ring_seq at N=4: directed vector table, async reset
// sequences, and a randomized run against a sequence-table reference model.
module tb_johnson_ring_seq;
  import johnson_pkg::*;

  localparam int N  = 4;
  localparam int PW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable, dir, mode, load;
  logic [N-1:0]  load_val;
  logic [N-1:0]  count;
  logic [PW-1:0] phase;
  logic          wrap, fault;

  always #5 clock = ~clock;

  johnson_ring_seq #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .dir      (dir),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .phase    (phase),
    .wrap     (wrap),
    .fault    (fault)
  );

  int checks = 0;
  int errors = 0;

  // Legal state sequences listed in phase order.
  logic [N-1:0] jseq [2*N];
  logic [N-1:0] rseq [N];

  // Reference model state.
  logic [N-1:0] m_count;
  logic         m_wrap, m_fault;

  typedef struct {
    logic         ld;
    logic [N-1:0] ld_val;
    logic         en;
    logic         dr;
    logic         md;
    logic [N-1:0] e_count;
    int           e_phase;
    logic         e_wrap;
    logic         e_fault;
  } vec_t;

  vec_t vecs [22];

  function automatic int find_idx(input logic md, input logic [N-1:0] v);
    if (md) begin
      for (int i = 0; i < N; i++) if (rseq[i] == v) return i;
    end else begin
      for (int i = 0; i < 2*N; i++) if (jseq[i] == v) return i;
    end
    return -1;
  endfunction

  function automatic int model_phase(input logic md, input logic [N-1:0] v);
    int idx;
    idx = find_idx(md, v);
    return (idx < 0) ? 0 : idx;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_step();
    int idx, len, ni;
    if (load) begin
      m_count = load_val; m_wrap = 0; m_fault = 0;
    end else if (enable) begin
      idx = find_idx(mode, m_count);
      len = mode ? N : 2*N;
      if (idx < 0) begin
        m_count = mode ? N'(1) : '0; m_wrap = 0; m_fault = 1;
      end else begin
        ni      = dir ? (idx + len - 1) % len : (idx + 1) % len;
        m_wrap  = dir ? (idx == 0) : (idx == len - 1);
        m_fault = 0;
        m_count = mode ? rseq[ni] : jseq[ni];
      end
    end else begin
      m_wrap = 0; m_fault = 0;
    end
  endtask

  task automatic model_reset();
    m_count = '0; m_wrap = 0; m_fault = 0;
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".count"}, int'(count), int'(m_count));
    chk({tag, ".phase"}, int'(phase), model_phase(mode, m_count));
    chk({tag, ".wrap"},  int'(wrap),  int'(m_wrap));
    chk({tag, ".fault"}, int'(fault), int'(m_fault));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic ld, input logic [N-1:0] lv, input logic en,
                        input logic dr, input logic md);
    load = ld; load_val = lv; enable = en; dir = dr; mode = md;
  endtask

  task automatic set_vec(input int i, input logic ld, input logic [N-1:0] lv,
                         input logic en, input logic dr, input logic md,
                         input logic [N-1:0] ec, input int ep, input logic ew,
                         input logic ef);
    vecs[i].ld = ld; vecs[i].ld_val = lv; vecs[i].en = en; vecs[i].dr = dr;
    vecs[i].md = md; vecs[i].e_count = ec; vecs[i].e_phase = ep;
    vecs[i].e_wrap = ew; vecs[i].e_fault = ef;
  endtask

  initial begin
    logic [N-1:0] tmp;
    logic         cause;

    for (int p = 0; p < 2*N; p++) begin
      if (p <= N) jseq[p] = N'((1 << p) - 1);
      else        jseq[p] = N'(((1 << N) - 1) ^ ((1 << (p - N)) - 1));
    end
    for (int i = 0; i < N; i++) rseq[i] = N'(1 << i);

    // Package legality helper against the enumerated sequences.
    for (int v = 0; v < (1 << N); v++) begin
      for (int md = 0; md < 2; md++) begin
        tmp = N'(v);
        chk($sformatf("legal_fn.m%0d.v%0d", md, v),
            int'(johnson_legal(MAX_N'(tmp), N, mode_e'(md[0]))),
            int'(find_idx(md[0], tmp) >= 0));
      end
    end

    // Directed vectors: ld, ld_val, en, dir, mode -> count, phase, wrap, fault.
    set_vec( 0, 0, 4'b0000, 1, 0, 0, 4'b0001, 1, 0, 0);
    set_vec( 1, 0, 4'b0000, 1, 0, 0, 4'b0011, 2, 0, 0);
    set_vec( 2, 0, 4'b0000, 1, 0, 0, 4'b0111, 3, 0, 0);
    set_vec( 3, 0, 4'b0000, 1, 0, 0, 4'b1111, 4, 0, 0);
    set_vec( 4, 0, 4'b0000, 1, 0, 0, 4'b1110, 5, 0, 0);
    set_vec( 5, 0, 4'b0000, 1, 0, 0, 4'b1100, 6, 0, 0);
    set_vec( 6, 0, 4'b0000, 1, 0, 0, 4'b1000, 7, 0, 0);
    set_vec( 7, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 1, 0);
    set_vec( 8, 0, 4'b0000, 1, 1, 0, 4'b1000, 7, 1, 0);
    set_vec( 9, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 1, 0);
    set_vec(10, 1, 4'b0101, 1, 0, 0, 4'b0101, 0, 0, 0);
    set_vec(11, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 1);
    set_vec(12, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    set_vec(13, 0, 4'b0000, 1, 0, 1, 4'b0001, 0, 0, 1);
    set_vec(14, 0, 4'b0000, 1, 0, 1, 4'b0010, 1, 0, 0);
    set_vec(15, 0, 4'b0000, 1, 0, 1, 4'b0100, 2, 0, 0);
    set_vec(16, 0, 4'b0000, 1, 0, 1, 4'b1000, 3, 0, 0);
    set_vec(17, 0, 4'b0000, 1, 0, 1, 4'b0001, 0, 1, 0);
    set_vec(18, 0, 4'b0000, 1, 1, 1, 4'b1000, 3, 1, 0);
    set_vec(19, 1, 4'b0111, 0, 0, 1, 4'b0111, 0, 0, 0);
    set_vec(20, 0, 4'b0000, 0, 0, 0, 4'b0111, 3, 0, 0);
    set_vec(21, 0, 4'b0000, 0, 0, 1, 4'b0111, 0, 0, 0);

    // Reset state.
    set_in(0, '0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst.count", int'(count), 0);
    chk("rst.phase", int'(phase), 0);
    chk("rst.wrap",  int'(wrap),  0);
    chk("rst.fault", int'(fault), 0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 22; i++) begin
      set_in(vecs[i].ld, vecs[i].ld_val, vecs[i].en, vecs[i].dr, vecs[i].md);
      cycle();
      chk($sformatf("vec%0d.count", i), int'(count), int'(vecs[i].e_count));
      chk($sformatf("vec%0d.phase", i), int'(phase), vecs[i].e_phase);
      chk($sformatf("vec%0d.wrap",  i), int'(wrap),  int'(vecs[i].e_wrap));
      chk($sformatf("vec%0d.fault", i), int'(fault), int'(vecs[i].e_fault));
    end

    // Async reset while count=0111 and load is requested.
    set_in(1, 4'b0111, 0, 0, 0);
    cycle();
    chk("pre_rst.count", int'(count), 7);
    set_in(1, 4'b1010, 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst.count", int'(count), 0);
    chk("async_rst.phase", int'(phase), 0);
    chk("async_rst.wrap",  int'(wrap),  0);
    chk("async_rst.fault", int'(fault), 0);
    @(posedge clock);
    #1;
    chk("rst_hold.count", int'(count), 0);
    reset = 1'b0;
    model_reset();

    // Async reset clears a pending wrap pulse.
    set_in(1, 4'b1000, 0, 0, 0);
    cycle();
    set_in(0, '0, 1, 0, 0);
    cycle();
    chk("wrap_before_rst", int'(wrap), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_clears_wrap", int'(wrap), 0);
    // Async reset clears a pending fault pulse.
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    set_in(1, 4'b0101, 0, 0, 0);
    cycle();
    set_in(0, '0, 1, 0, 0);
    cycle();
    chk("fault_before_rst", int'(fault), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_clears_fault", int'(fault), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    // Randomized run against the reference model.
    mode = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      load     = ($urandom_range(15) == 0);
      load_val = N'($urandom);
      enable   = ($urandom_range(3) != 0);
      dir      = 1'($urandom_range(1));
      if ($urandom_range(31) == 0) mode = ~mode;
      cause = enable && !load && (find_idx(mode, m_count) < 0);
      cycle();
      compare_model($sformatf("rnd%0d", c));
      chk($sformatf("rnd%0d.fault_cause", c), int'(fault && !cause), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
